wb_stage: RTL

- Writeback stage directly upstream of the register file. Drives its single write port (en, rd, data).
- Merges two result sources into that one port:
  - single-cycle ALU results, with a valid/ready handshake;
  - multi-cycle load results from memory, which have priority and are never back-pressured.
- Buffers ALU results that lose arbitration in a small in-order FIFO.
- Reports read-after-write hazards on pending results to decode.

---
 rtl/wb_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage merging load and ALU results onto one register-file write port
//
// Loads have priority and are never stalled. ALU results that lose arbitration
// wait in a small in-order FIFO and drain before any later ALU result may bypass.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   alu_valid/ready/rd/data ALU result handshake (accepted when valid && ready)
//   mem_valid/rd/data       load result, consumed unconditionally
//   rf_en/rd/data           registered register-file write port
//   chk_rs1, chk_rs2        decode source indices to check for pending writes
//   hazard                  a pending write targets chk_rs1 or chk_rs2
//   busy                    FIFO non-empty
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [RADDR-1:0] alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             mem_valid,
    input  logic [RADDR-1:0] mem_rd,
    input  logic [XLEN-1:0]  mem_data,
    output logic             rf_en,
    output logic [RADDR-1:0] rf_rd,
    output logic [XLEN-1:0]  rf_data,
    input  logic [RADDR-1:0] chk_rs1,
    input  logic [RADDR-1:0] chk_rs2,
    output logic             hazard,
    output logic             busy
);

    // A pointer needs at least one bit even when DEPTH == 1.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [RADDR-1:0] fifo_rd_q   [DEPTH];
    logic [XLEN-1:0]  fifo_data_q [DEPTH];
    logic [DEPTH-1:0] fifo_vld_q, fifo_vld_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic             rf_en_q, rf_en_d;
    logic [RADDR-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]  rf_data_q, rf_data_d;

    logic mem_req;
    logic alu_acc;
    logic alu_req;
    logic fifo_empty;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends on occupancy only; a same-cycle pop never frees a slot early.
    assign alu_ready  = (count_q < CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign busy       = !fifo_empty;

    assign mem_req = mem_valid && (mem_rd != '0);
    assign alu_acc = alu_valid && alu_ready;
    // Accepted beats to x0 are swallowed here and never reach the FIFO.
    assign alu_req = alu_acc && (alu_rd != '0);

    // Queue the ALU result whenever it cannot go straight to the port: either a
    // load owns the port or older ALU results are still waiting.
    assign push = alu_req && (mem_req || !fifo_empty);
    assign pop  = !mem_req && !fifo_empty;

    always_comb begin
        rf_en_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_data_d  = rf_data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fifo_vld_d = fifo_vld_q;

        if (mem_req) begin
            rf_en_d   = 1'b1;
            rf_rd_d   = mem_rd;
            rf_data_d = mem_data;
        end else if (!fifo_empty) begin
            rf_en_d   = 1'b1;
            rf_rd_d   = fifo_rd_q[head_q];
            rf_data_d = fifo_data_q[head_q];
        end else if (alu_req) begin
            rf_en_d   = 1'b1;
            rf_rd_d   = alu_rd;
            rf_data_d = alu_data;
        end

        if (pop) begin
            fifo_vld_d[head_q] = 1'b0;
            head_d             = ptr_inc(head_q);
        end
        if (push) begin
            fifo_vld_d[tail_q] = 1'b1;
            tail_d             = ptr_inc(tail_q);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fifo_vld_q <= '0;
            rf_en_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_data_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fifo_vld_q <= fifo_vld_d;
            rf_en_q    <= rf_en_d;
            rf_rd_q    <= rf_rd_d;
            rf_data_q  <= rf_data_d;
        end
    end

    // Payload storage needs no reset; the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_rd_q[tail_q]   <= alu_rd;
            fifo_data_q[tail_q] <= alu_data;
        end
    end

    assign rf_en   = rf_en_q;
    assign rf_rd   = rf_rd_q;
    assign rf_data = rf_data_q;

    // The register file reads combinationally before the rf_* write lands, so
    // the write currently on the port counts as pending too.
    function automatic logic pending(input logic [RADDR-1:0] x);
        logic hit;
        hit = 1'b0;
        if (x != '0) begin
            if (rf_en_q && (rf_rd_q == x)) hit = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (fifo_vld_q[i] && (fifo_rd_q[i] == x)) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign hazard = pending(chk_rs1) || pending(chk_rs2);

endmodule
